// File: rtl/snn_load_ctrl.sv
// Top-level sequencer for the SNN digit classifier: unpacks UART bytes into the
// 1-bit image RAM, starts snn_core, and returns the classified digit over UART TX.
//
// Handshake: rx_rdy, core_done and tx_start are single-cycle pulses. core_start pulses
// once per complete image. tx_start fires only in a cycle where tx_rdy is high.
// A byte is consumed only in IDLE; otherwise it is dropped and overrun is latched.
module snn_load_ctrl #(
    parameter int NUM_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    input  logic              tx_rdy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    output logic              core_start,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [7:0]        led,
    output logic              busy,
    output logic              overrun,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UNPACK    = 3'd1,
        S_START     = 3'd2,
        S_WAIT_CORE = 3'd3,
        S_SEND      = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BITS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        digit_q, digit_d;
    logic              overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            digit_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            digit_q   <= digit_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        digit_d    = digit_q;
        overrun_d  = overrun_q;
        ram_we     = 1'b0;
        ram_wdata  = 1'b0;
        ram_addr   = core_addr;
        core_start = 1'b0;
        tx_start   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_rdy) begin
                    shreg_d   = rx_data;
                    bit_cnt_d = 3'd0;
                    state_d   = S_UNPACK;
                end
            end
            S_UNPACK: begin
                ram_we    = 1'b1;
                ram_wdata = shreg_q[0];
                ram_addr  = wr_addr_q;
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                wr_addr_d = wr_addr_q + ADDR_W'(1);
                // The last pixel ends the image even mid-byte; leftover bits are discarded.
                if (wr_addr_q == LAST_ADDR) begin
                    state_d = S_START;
                end else if (bit_cnt_q == 3'd7) begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                core_start = 1'b1;
                wr_addr_d  = '0;
                state_d    = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (core_done) begin
                    digit_d = core_digit;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_rdy) begin
                    tx_start = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rx_rdy && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    assign tx_data   = {4'h0, digit_q};
    assign led       = {4'h0, digit_q};
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_snn_load_ctrl.sv
// Bench for snn_load_ctrl: a pixel-queue timeline model checked every cycle, plus
// literal expectations for the A5 byte, the image end, the reply digit and a 12-pixel image.
module tb_snn_load_ctrl;
    localparam int NUM_BITS = 784;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [9:0] core_addr = 10'h155;
    logic       core_done = 1'b0;
    logic [3:0] core_digit = 4'h0;
    logic       tx_rdy = 1'b0;
    logic       ram_we, ram_wdata, core_start, tx_start, busy, overrun;
    logic [9:0] ram_addr;
    logic [7:0] tx_data, led;
    logic [2:0] dbg_state;

    logic       rx_rdy2 = 1'b0;
    logic [7:0] rx_data2 = 8'h00;
    logic       ram_we2, ram_wdata2, core_start2, tx_start2, busy2, overrun2;
    logic [3:0] ram_addr2;
    logic [7:0] tx_data2, led2;
    logic [2:0] dbg_state2;

    int n_chk = 0;
    int n_fail = 0;

    snn_load_ctrl #(.NUM_BITS(NUM_BITS), .ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .core_addr(core_addr), .core_done(core_done), .core_digit(core_digit),
        .tx_rdy(tx_rdy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .core_start(core_start), .tx_start(tx_start), .tx_data(tx_data), .led(led),
        .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    snn_load_ctrl #(.NUM_BITS(12), .ADDR_W(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy2), .rx_data(rx_data2),
        .core_addr(4'd0), .core_done(1'b0), .core_digit(4'h0),
        .tx_rdy(1'b0), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
        .core_start(core_start2), .tx_start(tx_start2), .tx_data(tx_data2), .led(led2),
        .busy(busy2), .overrun(overrun2), .dbg_state(dbg_state2)
    );

    // clock/reset block
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 core_addr = core_addr + 10'd37;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: pending pixel writes plus a coarse phase (0 idle,1 start,2 wait core,3 send)
    logic [10:0] exp_q[$];
    int          m_left = 0;
    bit          m_final = 0;
    int          m_phase = 0;
    int          m_addr = 0;
    logic [3:0]  m_digit = 4'h0;
    bit          m_ovr = 0;
    bit          m_busy = 0;
    logic [10:0] e;
    logic [9:0]  wr_log_a[$];
    logic        wr_log_d[$];
    int          tx_cnt = 0;
    logic [7:0]  tx_last = 8'h00;
    logic [3:0]  log2_a[$];
    int          ones2 = 0;
    int          cs2_cnt = 0;

    // scoreboard: compare with the current model state, then advance it with the
    // inputs the DUT will sample at the next rising edge
    always @(negedge clk) begin
        m_busy = (m_left > 0) || (m_phase != 0);
        check("ram_we", 32'(ram_we), 32'(m_left > 0));
        if (m_left > 0) begin
            if (exp_q.size() == 0) begin
                check("exp_q_nonempty", 32'(0), 32'(1));
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(e[10:1]));
                check("wr_data", 32'(ram_wdata), 32'(e[0]));
            end
        end else begin
            check("ram_addr_mux", 32'(ram_addr), 32'(core_addr));
        end
        if (ram_we === 1'b1) begin
            wr_log_a.push_back(ram_addr);
            wr_log_d.push_back(ram_wdata);
        end
        check("core_start", 32'(core_start), 32'(m_phase == 1));
        check("tx_start", 32'(tx_start), 32'((m_phase == 3) && tx_rdy));
        check("busy", 32'(busy), 32'(m_busy));
        check("led", 32'(led), 32'({4'h0, m_digit}));
        check("tx_data", 32'(tx_data), 32'({4'h0, m_digit}));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (tx_start === 1'b1) begin
            tx_cnt++;
            tx_last = tx_data;
        end

        if (!rst_n) begin
            m_left = 0; m_final = 0; m_phase = 0; m_addr = 0; m_digit = 4'h0; m_ovr = 0;
            exp_q.delete();
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0 && m_final) begin
                    m_phase = 1;
                    m_final = 0;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2 && core_done) begin
                m_digit = core_digit;
                m_phase = 3;
            end else if (m_phase == 3 && tx_rdy) begin
                m_phase = 0;
            end
            if (rx_rdy) begin
                if (m_busy) begin
                    m_ovr = 1;
                end else begin
                    for (int k = 0; k < 8; k++) begin
                        exp_q.push_back({m_addr[9:0], rx_data[k]});
                        m_left++;
                        if (m_addr == NUM_BITS - 1) begin
                            m_final = 1;
                            m_addr = 0;
                            break;
                        end
                        m_addr++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ram_we2 === 1'b1) begin
            log2_a.push_back(ram_addr2);
            if (ram_wdata2 === 1'b1) ones2++;
        end
        if (core_start2 === 1'b1) cs2_cnt++;
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input int drop_at);
        rx_data = b;
        rx_rdy = 1'b1;
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == drop_at) begin
                rx_rdy = 1'b1;
                rx_data = ~b;
            end
            @(posedge clk); #1;
            rx_rdy = 1'b0;
        end
    endtask

    task automatic send_image(input int first_idx);
        for (int i = first_idx; i < NUM_BITS / 8; i++) begin
            send_byte(8'(i * 29 + 5), (i == 10) ? 3 : 0);
        end
    endtask

    task automatic pulse_done(input logic [3:0] d);
        core_digit = d;
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
    endtask

    task automatic drop_byte();
        rx_data = 8'h3C;
        rx_rdy = 1'b1;
        @(posedge clk); #1;
        rx_rdy = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base;
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ram_we", 32'(ram_we), 32'(0));
        check("rst_core_start", 32'(core_start), 32'(0));
        check("rst_tx_start", 32'(tx_start), 32'(0));
        check("rst_led", 32'(led), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        pulse_done(4'h9);
        @(negedge clk);
        check("done_in_idle_led", 32'(led), 32'(0));
        @(posedge clk); #1;

        send_byte(8'hA5, 0);
        check("a5_count", 32'(wr_log_a.size()), 32'(8));
        for (int i = 0; i < 8; i++) begin
            check("a5_addr", 32'(wr_log_a[i]), 32'(i));
        end
        check("a5_bits", 32'({wr_log_d[0], wr_log_d[1], wr_log_d[2], wr_log_d[3],
                              wr_log_d[4], wr_log_d[5], wr_log_d[6], wr_log_d[7]}), 32'(8'b10100101));
        @(negedge clk);
        check("a5_idle_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;

        send_image(1);
        check("img1_count", 32'(wr_log_a.size()), 32'(784));
        check("img1_last_addr", 32'(wr_log_a[783]), 32'(783));
        check("overrun_unpack", 32'(overrun), 32'(1));
        repeat (4) @(posedge clk); #1;
        drop_byte();
        repeat (3) @(posedge clk); #1;
        pulse_done(4'h7);
        @(negedge clk);
        check("led_7", 32'(led), 32'(8'h07));
        repeat (20) @(posedge clk); #1;
        tx_rdy = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("tx_once", 32'(tx_cnt), 32'(1));
        check("tx_data_7", 32'(tx_last), 32'(8'h07));

        for (int i = 0; i < 50; i++) send_byte(8'(i * 13 + 1), 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_overrun_clr", 32'(overrun), 32'(0));
        base = wr_log_a.size();
        send_image(11);
        for (int i = 0; i < 11; i++) send_byte(8'(i * 7 + 2), 0);
        check("img2_first_addr", 32'(wr_log_a[base]), 32'(0));
        check("img2_count", 32'(wr_log_a.size() - base), 32'(784));
        repeat (2) @(posedge clk); #1;
        drop_byte();
        check("overrun_wait", 32'(overrun), 32'(1));
        pulse_done(4'h3);
        repeat (3) @(posedge clk); #1;
        check("tx_twice", 32'(tx_cnt), 32'(2));
        check("tx_data_3", 32'(tx_last), 32'(8'h03));
        check("led_3", 32'(led), 32'(8'h03));

        rx_data2 = 8'hFF;
        rx_rdy2 = 1'b1;
        @(posedge clk); #1;
        rx_rdy2 = 1'b0;
        repeat (9) @(posedge clk); #1;
        rx_data2 = 8'h0F;
        rx_rdy2 = 1'b1;
        @(posedge clk); #1;
        rx_rdy2 = 1'b0;
        repeat (8) @(posedge clk); #1;
        check("n12_count", 32'(log2_a.size()), 32'(12));
        check("n12_last_addr", 32'(log2_a[log2_a.size() - 1]), 32'(11));
        check("n12_ones", 32'(ones2), 32'(12));
        check("n12_start", 32'(cs2_cnt), 32'(1));
        check("n12_busy_wait", 32'(busy2), 32'(1));
        check("end_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
